// File: rtl/ringbuf2daq.sv
// ringbuf2daq: read side of the DCFEB sample ring buffer.
// Fetches NSAMP x 16 words per L1A descriptor and streams them to the DAQ FIFO.
module ringbuf2daq #(
   parameter int RB_AW = 11
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             EVT_RDY,
   input  logic [RB_AW-1:0] EVT_ADDR,
   input  logic [4:0]       NSAMP,
   output logic             EVT_ACK,
   output logic             RB_REN,
   output logic [RB_AW-1:0] RB_RADDR,
   input  logic [11:0]      RB_DIN,
   input  logic             OUT_AFULL,
   output logic [11:0]      DOUT,
   output logic             DOUT_WE,
   output logic             DOUT_FIRST,
   output logic             DOUT_LAST,
   output logic             BUSY,
   output logic             DONE
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_READ,
      S_DRAIN,
      S_DONE
   } state_t;

   localparam logic [RB_AW-1:0] ADDR_ONE = {{(RB_AW-1){1'b0}}, 1'b1};

   state_t           state;
   logic [RB_AW-1:0] addr;
   logic [9:0]       icnt;
   logic             first_pend;
   logic             v1;
   logic             f1;
   logic             l1;
   logic             issue;
   logic             last_issue;

   // Backpressure gates the issue in the same cycle; in-flight reads still land.
   assign issue      = (state == S_READ) && !OUT_AFULL;
   assign last_issue = (icnt == 10'd1);
   assign RB_REN     = issue;
   assign RB_RADDR   = addr;

   always_ff @(posedge CLK) begin
      if (RST) begin
         state      <= S_IDLE;
         addr       <= '0;
         icnt       <= '0;
         first_pend <= 1'b0;
         v1         <= 1'b0;
         f1         <= 1'b0;
         l1         <= 1'b0;
         DOUT       <= '0;
         DOUT_WE    <= 1'b0;
         DOUT_FIRST <= 1'b0;
         DOUT_LAST  <= 1'b0;
         EVT_ACK    <= 1'b0;
         BUSY       <= 1'b0;
         DONE       <= 1'b0;
      end else begin
         EVT_ACK    <= 1'b0;
         DONE       <= 1'b0;
         v1         <= issue;
         f1         <= issue && first_pend;
         l1         <= issue && last_issue;
         DOUT_WE    <= v1;
         DOUT_FIRST <= f1;
         DOUT_LAST  <= l1;
         if (v1) DOUT <= RB_DIN;

         unique case (state)
            S_IDLE: begin
               if (EVT_RDY) begin
                  state   <= S_LOAD;
                  EVT_ACK <= 1'b1;
                  BUSY    <= 1'b1;
               end
            end
            S_LOAD: begin
               addr       <= EVT_ADDR;
               icnt       <= (NSAMP == 5'd0) ? 10'd512 : {1'b0, NSAMP, 4'd0};
               first_pend <= 1'b1;
               state      <= S_READ;
            end
            S_READ: begin
               if (issue) begin
                  addr       <= addr + ADDR_ONE;
                  icnt       <= icnt - 10'd1;
                  first_pend <= 1'b0;
                  if (last_issue) state <= S_DRAIN;
               end
            end
            S_DRAIN: begin
               if (DOUT_WE && DOUT_LAST) begin
                  state <= S_DONE;
                  DONE  <= 1'b1;
               end
            end
            S_DONE: begin
               state <= S_IDLE;
               BUSY  <= 1'b0;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule
